// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared definitions for the serial magnitude comparator slice.
// Holds the one-hot compare codes {gt,lt,eq}, the FSM state encoding,
// and small helpers that decode a per-bit code beat.
package serial_magnitude_comparator_pkg;

    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_LT = 3'b010;
    localparam logic [2:0] CMP_EQ = 3'b001;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_DONE    = 1'b1
    } state_t;

    // gt has priority over lt; anything else counts as equal
    function automatic logic [2:0] code_decode(input logic [2:0] code);
        logic [2:0] res;
        casez (code)
            3'b1??:  res = CMP_GT;
            3'b01?:  res = CMP_LT;
            default: res = CMP_EQ;
        endcase
        return res;
    endfunction

    // true when the beat settles the word (decoded gt or lt)
    function automatic logic code_resolves(input logic [2:0] code);
        return code_decode(code) != CMP_EQ;
    endfunction

    // true for any code that is not exactly one-hot
    function automatic logic code_illegal(input logic [2:0] code);
        return !((code == CMP_GT) || (code == CMP_LT) || (code == CMP_EQ));
    endfunction

endpackage

// File: rtl/serial_magnitude_comparator_beat_counter.sv
// sercmp_beat_counter: WIDTH-parameterised beat up-counter.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   clr  - synchronous clear
//   inc  - advance by one beat
//   last - count == WIDTH-1 (current beat is the last of the word)
// The counter returns to zero when the last beat is taken, so it never
// leaves the range 0..WIDTH-1 even for non power-of-two widths.
module sercmp_beat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic last
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [CW-1:0] count;

    assign last = (count == CW'(WIDTH - 1));

    // beat count within the current word
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= last ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator: resolves a WIDTH-bit magnitude compare from a
// stream of per-bit one-hot codes {gt,lt,eq}, MSB beat first. The first
// non-equal beat decides the word; one result is offered per word.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   in_valid/in_ready     - code beat handshake, in_code = {gt,lt,eq}
//   out_valid/out_ready   - word result handshake
//   out_res               - one-hot word result {gt,lt,eq}
//   out_err               - non one-hot code seen in this word
// Build option: define SERCMP_ERR_EN to enable the error flag; otherwise
// out_err is tied to 0 and the port list is unchanged.
module serial_magnitude_comparator
    import serial_magnitude_comparator_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_code,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_res,
    output logic       out_err
);

    state_t     state;
    logic       resolved;
    logic [2:0] latched;
    logic       accept;
    logic       last;
    logic       clr;
    logic [2:0] dec;
    logic       hit;

    assign accept = in_valid && in_ready;
    assign clr    = (state == ST_DONE) && out_ready;
    assign dec    = code_decode(in_code);
    assign hit    = code_resolves(in_code);

    sercmp_beat_counter #(
        .WIDTH (WIDTH)
    ) u_beat_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .inc  (accept),
        .last (last)
    );

`ifdef SERCMP_ERR_EN
    logic err;
    logic bad;
    assign bad = code_illegal(in_code);

    // sticky per-word illegal-code flag, reported with the result
    always_ff @(posedge clk) begin
        if (rst) begin
            err     <= 1'b0;
            out_err <= 1'b0;
        end else if (state == ST_COLLECT) begin
            if (accept) begin
                err <= err | bad;
                if (last) begin
                    out_err <= err | bad;
                end
            end
        end else if (out_ready) begin
            err     <= 1'b0;
            out_err <= 1'b0;
        end
    end
`else
    assign out_err = 1'b0;
`endif

    // word FSM, resolve latch and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_COLLECT;
            resolved  <= 1'b0;
            latched   <= CMP_EQ;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_res   <= 3'b000;
        end else begin
            case (state)
                ST_COLLECT: begin
                    if (accept) begin
                        if (!resolved && hit) begin
                            resolved <= 1'b1;
                            latched  <= dec;
                        end
                        if (last) begin
                            out_res   <= resolved ? latched : (hit ? dec : CMP_EQ);
                            state     <= ST_DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_COLLECT;
                        resolved  <= 1'b0;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench for serial_magnitude_comparator at WIDTH=4.
module tb_serial_magnitude_comparator;

    localparam int unsigned WIDTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_code;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_res;
    logic       out_err;

    typedef struct packed {
        logic [2:0] res;
        logic       err;
    } exp_t;

    exp_t sbq[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   gap_run  = 0;
    int   last_gap = -1;
    bit   rnd_done = 1'b0;

    always #5 clk = ~clk;

    serial_magnitude_comparator #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_err   (out_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference: first non-equal beat wins, gt over lt
    function automatic exp_t model(input logic [11:0] w);
        exp_t       e;
        logic [2:0] c;
        bit         done;
        e.res = 3'b001;
        e.err = 1'b0;
        done  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            c = w[11-3*i -: 3];
            if (!done && c[2]) begin
                e.res = 3'b100;
                done  = 1'b1;
            end else if (!done && c[1]) begin
                e.res = 3'b010;
                done  = 1'b1;
            end
`ifdef SERCMP_ERR_EN
            if (!(c == 3'b100 || c == 3'b010 || c == 3'b001)) e.err = 1'b1;
`endif
        end
        return e;
    endfunction

    // scoreboard pop on every result handoff
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                check("sb_unexpected", 32'(1), 32'(0));
            end else begin
                e = sbq.pop_front();
                check("res", 32'(out_res), 32'(e.res));
                check("err", 32'(out_err), 32'(e.err));
            end
        end
    end

    // length of in_ready=0 gaps
    always @(negedge clk) begin
        if (rst) begin
            gap_run = 0;
        end else if (!in_ready) begin
            gap_run++;
        end else begin
            if (gap_run > 0) last_gap = gap_run;
            gap_run = 0;
        end
    end

    task automatic beat(input logic [2:0] c);
        bit ok;
        in_valid = 1'b1;
        in_code  = c;
        ok       = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) check("beat_timeout", 32'(0), 32'(1));
    endtask

    task automatic send_word(input logic [11:0] w);
        for (int i = 0; i < 4; i++) beat(w[11-3*i -: 3]);
        in_valid = 1'b0;
        sbq.push_back(model(w));
    endtask

    initial begin
        logic [11:0] w;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_code   = 3'b000;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_res",   32'(out_res),   32'(0));
        check("rst_out_err",   32'(out_err),   32'(0));
        check("rst_in_ready",  32'(in_ready),  32'(1));
        @(posedge clk);
        #1;

        // 1: gt at third beat, latency and single-cycle valid
        send_word({3'b001, 3'b001, 3'b100, 3'b001});
        @(negedge clk);
        check("t1_valid_lat", 32'(out_valid), 32'(1));
        check("t1_res_lat",   32'(out_res),   32'(3'b100));
        @(negedge clk);
        check("t1_valid_1cyc", 32'(out_valid), 32'(0));
        @(posedge clk);
        #1;

        // 2: first difference wins
        send_word({3'b010, 3'b100, 3'b100, 3'b100});

        // 3: equal words back-to-back
        send_word({3'b001, 3'b001, 3'b001, 3'b001});
        send_word({3'b001, 3'b001, 3'b001, 3'b001});
        repeat (3) @(posedge clk);
        #1;
        check("t3_gap", 32'(last_gap), 32'(1));

        // 4: backpressure in DONE
        out_ready = 1'b0;
        send_word({3'b100, 3'b001, 3'b001, 3'b001});
        in_valid = 1'b1;
        in_code  = 3'b010;
        repeat (5) begin
            @(negedge clk);
            check("t4_valid_hold", 32'(out_valid), 32'(1));
            check("t4_res_hold",   32'(out_res),   32'(3'b100));
            check("t4_in_ready",   32'(in_ready),  32'(0));
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send_word({3'b010, 3'b001, 3'b001, 3'b001});

        // 5: reset mid-word discards the partial word
        beat(3'b100);
        beat(3'b100);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t5_out_valid", 32'(out_valid), 32'(0));
        check("t5_in_ready",  32'(in_ready),  32'(1));
        @(posedge clk);
        #1;
        send_word({3'b010, 3'b001, 3'b001, 3'b001});

        // 6: illegal code flags only its own word
        send_word({3'b001, 3'b000, 3'b001, 3'b001});
        send_word({3'b001, 3'b001, 3'b001, 3'b001});
        send_word({3'b001, 3'b110, 3'b010, 3'b001});
        send_word({3'b011, 3'b000, 3'b111, 3'b101});

        // random words under random backpressure
        fork
            begin
                for (int n = 0; n < 30; n++) begin
                    w = 12'($urandom_range(0, 4095));
                    send_word(w);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;

        for (int t = 0; t < 100 && sbq.size() != 0; t++) @(posedge clk);
        repeat (2) @(posedge clk);
        check("sb_drain", 32'(sbq.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
